// File: rtl/uart_host_driver.sv
// uart_host_driver
// Host-side UART driver for an inference accelerator. On a start request it
// latches an N_TX_BYTES payload, streams it out on tx as back-to-back 8N1
// frames (byte 0 first, LSB first), then collects N_RX_BYTES result frames
// from rx. A timeout and a framing error are reported as sticky flags.
//
// Optional feature macro: ARGMAX_EN. When defined, argmax is updated in
// FINISH with the index of the largest two's-complement result byte (ties go
// to the lowest index). When undefined, argmax is tied to 0 and no comparator
// is built.
//
// Ports
//   clk_100MHz     : only clock, all flops on its rising edge
//   rst            : asynchronous active-high reset
//   start          : one-cycle request, ignored while busy
//   in_vector_flat : payload, byte k = bits [8k+7:8k]
//   rx             : serial input from the accelerator
//   tx             : serial output to the accelerator (idles high)
//   busy           : high from the accepted start until back in IDLE
//   done           : one-cycle pulse after all result bytes arrived
//   result_flat    : received bytes, byte j = bits [8j+7:8j]
//   argmax         : index of the largest signed result byte
//   timeout_err    : sticky, no result byte arrived within TIMEOUT_CYCLES
//   frame_err      : sticky, a result frame had a low stop bit
module uart_host_driver #(
   parameter int CLKS_PER_BIT   = 868,
   parameter int N_TX_BYTES     = 64,
   parameter int N_RX_BYTES     = 10,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                    clk_100MHz,
   input  logic                    rst,
   input  logic                    start,
   input  logic [8*N_TX_BYTES-1:0] in_vector_flat,
   input  logic                    rx,
   output logic                    tx,
   output logic                    busy,
   output logic                    done,
   output logic [8*N_RX_BYTES-1:0] result_flat,
   output logic [3:0]              argmax,
   output logic                    timeout_err,
   output logic                    frame_err
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
   localparam int TXB_W  = $clog2(N_TX_BYTES + 1);
   localparam int RXB_W  = $clog2(N_RX_BYTES + 1);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [TXB_W-1:0]  TX_LAST   = TXB_W'(N_TX_BYTES - 1);
   localparam logic [TXB_W-1:0]  TX_ONE    = TXB_W'(1);
   localparam logic [RXB_W-1:0]  RX_LAST   = RXB_W'(N_RX_BYTES - 1);
   localparam logic [RXB_W-1:0]  RX_ONE    = RXB_W'(1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      SEND_BYTE = 3'd2,
      WAIT_RX   = 3'd3,
      RECV_BYTE = 3'd4,
      FINISH    = 3'd5
   } state_t;

   state_t                  state_r, state_nx_s;
   logic [8*N_TX_BYTES-1:0] tx_buf_r, buf_nx_s;
   // One baud counter and bit index serve both directions; tx and rx never overlap.
   logic [BAUD_W-1:0]       baud_cnt_r, baud_nx_s;
   logic [3:0]              bit_idx_r, bit_nx_s;
   logic [TXB_W-1:0]        tx_byte_r, tx_byte_nx_s;
   logic [RXB_W-1:0]        rx_byte_r, rx_byte_nx_s;
   logic [TMO_W-1:0]        wait_cnt_r, wait_nx_s;
   logic [7:0]              rx_shift_r, shift_nx_s;
   logic [8*N_RX_BYTES-1:0] result_r, result_nx_s;
   logic                    timeout_r, timeout_nx_s;
   logic                    frame_r, frame_nx_s;
   logic                    rx_meta_r, rx_sync_r, rx_prev_r;
   logic                    tx_r, tx_nx_s;
   logic                    busy_r, done_r;
   logic [7:0]              cur_byte_s;

   // Two-flop synchronizer for rx plus one delay stage for falling-edge detection
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
      end
   end

   // Next-state and datapath updates for the transaction FSM
   always_comb begin
      state_nx_s   = state_r;
      buf_nx_s     = tx_buf_r;
      baud_nx_s    = baud_cnt_r;
      bit_nx_s     = bit_idx_r;
      tx_byte_nx_s = tx_byte_r;
      rx_byte_nx_s = rx_byte_r;
      wait_nx_s    = wait_cnt_r;
      shift_nx_s   = rx_shift_r;
      result_nx_s  = result_r;
      timeout_nx_s = timeout_r;
      frame_nx_s   = frame_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = LOAD;
            end else begin
               state_nx_s = IDLE;
            end
         end
         LOAD: begin
            buf_nx_s     = in_vector_flat;
            result_nx_s  = '0;
            timeout_nx_s = 1'b0;
            frame_nx_s   = 1'b0;
            baud_nx_s    = '0;
            bit_nx_s     = 4'd0;
            tx_byte_nx_s = '0;
            rx_byte_nx_s = '0;
            wait_nx_s    = '0;
            state_nx_s   = SEND_BYTE;
         end
         SEND_BYTE: begin
            // bit_idx 0 = start, 1..8 = data, 9 = stop
            if (baud_cnt_r == BIT_LAST) begin
               baud_nx_s = '0;
               if (bit_idx_r == 4'd9) begin
                  bit_nx_s = 4'd0;
                  if (tx_byte_r == TX_LAST) begin
                     wait_nx_s  = '0;
                     state_nx_s = WAIT_RX;
                  end else begin
                     tx_byte_nx_s = tx_byte_r + TX_ONE;
                  end
               end else begin
                  bit_nx_s = bit_idx_r + 4'd1;
               end
            end else begin
               baud_nx_s = baud_cnt_r + BAUD_ONE;
            end
         end
         WAIT_RX: begin
            if (rx_prev_r && !rx_sync_r) begin
               baud_nx_s  = '0;
               bit_nx_s   = 4'd0;
               state_nx_s = RECV_BYTE;
            end else if (wait_cnt_r == TMO_LAST) begin
               timeout_nx_s = 1'b1;
               state_nx_s   = IDLE;
            end else begin
               wait_nx_s = wait_cnt_r + TMO_ONE;
            end
         end
         RECV_BYTE: begin
            if (bit_idx_r == 4'd0) begin
               // Half a bit after the edge: a high line here was a glitch, not a start bit
               if (baud_cnt_r == HALF_LAST) begin
                  baud_nx_s = '0;
                  if (!rx_sync_r) begin
                     bit_nx_s = 4'd1;
                  end else begin
                     wait_nx_s  = '0;
                     state_nx_s = WAIT_RX;
                  end
               end else begin
                  baud_nx_s = baud_cnt_r + BAUD_ONE;
               end
            end else if (baud_cnt_r == BIT_LAST) begin
               baud_nx_s = '0;
               if (bit_idx_r == 4'd9) begin
                  // Stop-bit centre: the byte is kept even when the stop bit is bad
                  for (int j = 0; j < N_RX_BYTES; j++) begin
                     result_nx_s[8*j +: 8] = (rx_byte_r == RXB_W'(j)) ? rx_shift_r
                                                                       : result_r[8*j +: 8];
                  end
                  frame_nx_s = frame_r | ~rx_sync_r;
                  bit_nx_s   = 4'd0;
                  wait_nx_s  = '0;
                  if (rx_byte_r == RX_LAST) begin
                     state_nx_s = FINISH;
                  end else begin
                     rx_byte_nx_s = rx_byte_r + RX_ONE;
                     state_nx_s   = WAIT_RX;
                  end
               end else begin
                  shift_nx_s = {rx_sync_r, rx_shift_r[7:1]};
                  bit_nx_s   = bit_idx_r + 4'd1;
               end
            end else begin
               baud_nx_s = baud_cnt_r + BAUD_ONE;
            end
         end
         FINISH: begin
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Line level for the next cycle, taken from next-state values so tx is a plain flop
   always_comb begin
      cur_byte_s = 8'h00;
      for (int k = 0; k < N_TX_BYTES; k++) begin
         cur_byte_s = (tx_byte_nx_s == TXB_W'(k)) ? buf_nx_s[8*k +: 8] : cur_byte_s;
      end
      if (state_nx_s == SEND_BYTE) begin
         case (bit_nx_s)
            4'd0:    tx_nx_s = 1'b0;
            4'd1:    tx_nx_s = cur_byte_s[0];
            4'd2:    tx_nx_s = cur_byte_s[1];
            4'd3:    tx_nx_s = cur_byte_s[2];
            4'd4:    tx_nx_s = cur_byte_s[3];
            4'd5:    tx_nx_s = cur_byte_s[4];
            4'd6:    tx_nx_s = cur_byte_s[5];
            4'd7:    tx_nx_s = cur_byte_s[6];
            4'd8:    tx_nx_s = cur_byte_s[7];
            default: tx_nx_s = 1'b1;
         endcase
      end else begin
         tx_nx_s = 1'b1;
      end
   end

   // FSM state, datapath and registered outputs
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         tx_buf_r   <= '0;
         baud_cnt_r <= '0;
         bit_idx_r  <= 4'd0;
         tx_byte_r  <= '0;
         rx_byte_r  <= '0;
         wait_cnt_r <= '0;
         rx_shift_r <= 8'h00;
         result_r   <= '0;
         timeout_r  <= 1'b0;
         frame_r    <= 1'b0;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         tx_buf_r   <= buf_nx_s;
         baud_cnt_r <= baud_nx_s;
         bit_idx_r  <= bit_nx_s;
         tx_byte_r  <= tx_byte_nx_s;
         rx_byte_r  <= rx_byte_nx_s;
         wait_cnt_r <= wait_nx_s;
         rx_shift_r <= shift_nx_s;
         result_r   <= result_nx_s;
         timeout_r  <= timeout_nx_s;
         frame_r    <= frame_nx_s;
         tx_r       <= tx_nx_s;
         busy_r     <= (state_nx_s != IDLE);
         done_r     <= (state_r == FINISH);
      end
   end

`ifdef ARGMAX_EN
   logic [3:0] argmax_r;

   // Index of the largest signed byte; strict compare keeps the lowest index on ties
   function automatic logic [3:0] argmax_f(input logic [8*N_RX_BYTES-1:0] v);
      logic signed [7:0] best_v;
      logic [3:0]        idx_v;
      best_v = $signed(v[7:0]);
      idx_v  = 4'd0;
      for (int j = 1; j < N_RX_BYTES; j++) begin
         if ($signed(v[8*j +: 8]) > best_v) begin
            best_v = $signed(v[8*j +: 8]);
            idx_v  = 4'(j);
         end else begin
            idx_v  = idx_v;
         end
      end
      return idx_v;
   endfunction

   // Capture argmax while in FINISH so it is valid together with done
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         argmax_r <= 4'd0;
      end else if (state_r == FINISH) begin
         argmax_r <= argmax_f(result_r);
      end else begin
         argmax_r <= argmax_r;
      end
   end

   assign argmax = argmax_r;
`else
   assign argmax = 4'd0;
`endif

   assign tx          = tx_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign result_flat = result_r;
   assign timeout_err = timeout_r;
   assign frame_err   = frame_r;

endmodule

// File: tb/tb_uart_host_driver.sv
// tb_uart_host_driver
// Self-checking bench for uart_host_driver. A line decoder watches tx and
// queues every frame with its start time; an accelerator stand-in answers on
// rx. Expected frames, results, flags and argmax are computed from the
// payload and response tables with plain arithmetic.
module tb_uart_host_driver;

   localparam int CPB = 8;
   localparam int NTX = 64;
   localparam int NRX = 10;
   localparam int TMO = 1000;
   localparam int PER = 10;

   logic               clk_100MHz = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               rx = 1'b1;
   logic [8*NTX-1:0]   in_vector_flat = '0;
   logic               tx;
   logic               busy;
   logic               done;
   logic [8*NRX-1:0]   result_flat;
   logic [3:0]         argmax;
   logic               timeout_err;
   logic               frame_err;

   int                 n_checks = 0;
   int                 n_errors = 0;
   logic [7:0]         tx_q[$];
   time                fstamp_q[$];
   logic [7:0]         mon_b;
   time                mon_t;
   int                 done_cnt = 0;
   logic [8*NRX-1:0]   result_at_done = '0;
   logic [3:0]         argmax_at_done = 4'd0;
   logic [8*NTX-1:0]   pay_v;
   logic [7:0]         resp_a [NRX];
   time                last_stop_t;

   uart_host_driver #(
      .CLKS_PER_BIT   (CPB),
      .N_TX_BYTES     (NTX),
      .N_RX_BYTES     (NRX),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_100MHz     (clk_100MHz),
      .rst            (rst),
      .start          (start),
      .in_vector_flat (in_vector_flat),
      .rx             (rx),
      .tx             (tx),
      .busy           (busy),
      .done           (done),
      .result_flat    (result_flat),
      .argmax         (argmax),
      .timeout_err    (timeout_err),
      .frame_err      (frame_err)
   );

   // 100 MHz clock
   always #5 clk_100MHz = ~clk_100MHz;

   // Count done pulses and snapshot the outputs that must be valid with done
   always @(negedge clk_100MHz) begin
      if (done) begin
         done_cnt       <= done_cnt + 1;
         result_at_done <= result_flat;
         argmax_at_done <= argmax;
      end
   end

   // Decode tx frames at bit centres
   initial begin
      forever begin
         @(negedge tx);
         mon_t = $time;
         repeat (CPB / 2) @(negedge clk_100MHz);
         if (tx == 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk_100MHz);
               mon_b[i] = tx;
            end
            repeat (CPB) @(negedge clk_100MHz);
            tx_q.push_back(mon_b);
            fstamp_q.push_back(mon_t);
         end
      end
   end

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference argmax: two's-complement value of each byte, first maximum wins
   function automatic logic [3:0] ref_argmax();
      int best;
      int idx;
      int v;
      best = -129;
      idx  = 0;
      for (int j = 0; j < NRX; j++) begin
         v = int'(resp_a[j]);
         if (v > 127) v = v - 256;
         if (v > best) begin
            best = v;
            idx  = j;
         end
      end
      return 4'(idx);
   endfunction

   // Accelerator stand-in: one 8N1 frame followed by two idle bit times
   task automatic uart_send(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk_100MHz);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk_100MHz);
      end
      rx = stop_bit;
      last_stop_t = $time;
      repeat (CPB) @(negedge clk_100MHz);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk_100MHz);
   endtask

   // One request with pay_v, answered with the first n_resp entries of resp_a.
   // bad_idx selects a response frame with a low stop bit; restart_at re-pulses start mid-send.
   task automatic run_txn(input string tag, input int n_resp, input int bad_idx, input int restart_at);
      int               q_base;
      int               d_base;
      int               nf;
      int               bad;
      int               c;
      int               dly;
      time              t_start;
      time              t_to;
      logic [8*NRX-1:0] exp_res;
      logic [3:0]       exp_am;
      logic             complete;

      q_base = tx_q.size();
      d_base = done_cnt;
      in_vector_flat = pay_v;
      start = 1'b1;
      t_start = $time - 64'd5;
      @(negedge clk_100MHz);
      start = 1'b0;
      c = 0;
      while (c < NTX * 10 * CPB + 200 && (tx_q.size() - q_base) < NTX) begin
         if (c == restart_at) start = 1'b1;
         else start = 1'b0;
         @(negedge clk_100MHz);
         c++;
      end
      start = 1'b0;

      nf = tx_q.size() - q_base;
      check_val({tag, " result cleared"}, 128'(result_flat), 128'(0));
      check_val({tag, " busy sending"}, 128'(busy), 128'(1));
      if (nf > 0) begin
         check_val({tag, " start latency"}, 128'(fstamp_q[q_base] - t_start), 128'(2 * PER));
      end
      bad = 0;
      for (int k = 0; k < nf; k++) begin
         if (tx_q[q_base + k] !== pay_v[8*k +: 8]) bad++;
         if (k > 0 && (fstamp_q[q_base + k] - fstamp_q[q_base + k - 1]) != 64'(10 * CPB * PER)) bad++;
      end
      check_val({tag, " tx bytes and spacing"}, 128'(bad), 128'(0));

      repeat (CPB) @(negedge clk_100MHz);
      for (int j = 0; j < n_resp; j++) begin
         uart_send(resp_a[j], (j == bad_idx) ? 1'b0 : 1'b1);
      end
      c = 0;
      while (c < TMO + 20 * CPB && done_cnt == d_base && !timeout_err) begin
         @(negedge clk_100MHz);
         c++;
      end
      t_to = $time;
      repeat (3) @(negedge clk_100MHz);

      complete = (n_resp == NRX);
      exp_res = '0;
      for (int j = 0; j < n_resp; j++) exp_res[8*j +: 8] = resp_a[j];
`ifdef ARGMAX_EN
      exp_am = ref_argmax();
`else
      exp_am = 4'd0;
`endif
      check_val({tag, " done pulses"}, 128'(done_cnt - d_base), complete ? 128'(1) : 128'(0));
      check_val({tag, " timeout_err"}, 128'(timeout_err), 128'(!complete));
      check_val({tag, " frame_err"}, 128'(frame_err), 128'(bad_idx >= 0 && bad_idx < n_resp));
      check_val({tag, " busy idle"}, 128'(busy), 128'(0));
      check_val({tag, " result_flat"}, 128'(result_flat), 128'(exp_res));
      if (complete) begin
         check_val({tag, " result at done"}, 128'(result_at_done), 128'(exp_res));
         check_val({tag, " argmax at done"}, 128'(argmax_at_done), 128'(exp_am));
      end else begin
         dly = int'((t_to - last_stop_t) / PER);
         check_val({tag, " timeout delay in window"}, 128'(dly >= TMO && dly <= TMO + CPB + 4), 128'(1));
      end
      repeat (20) @(negedge clk_100MHz);
      check_val({tag, " result hold"}, 128'(result_flat), 128'(exp_res));
      check_val({tag, " frame count"}, 128'(tx_q.size() - q_base), 128'(NTX));
   endtask

   initial begin : main
      int q_base;
      int c;

      repeat (3) @(negedge clk_100MHz);
      check_val("reset tx", 128'(tx), 128'(1));
      check_val("reset busy", 128'(busy), 128'(0));
      check_val("reset done", 128'(done), 128'(0));
      check_val("reset result", 128'(result_flat), 128'(0));
      check_val("reset argmax", 128'(argmax), 128'(0));
      check_val("reset timeout_err", 128'(timeout_err), 128'(0));
      check_val("reset frame_err", 128'(frame_err), 128'(0));
      rst = 1'b0;
      repeat (3) @(negedge clk_100MHz);

      // Counting payload, echo of 0..9
      for (int k = 0; k < NTX; k++) pay_v[8*k +: 8] = 8'(k);
      for (int j = 0; j < NRX; j++) resp_a[j] = 8'(j);
      run_txn("echo", NRX, -1, -1);

      // Signed tie: 0x7F at 1 and 3, 0x80 is -128
      for (int k = 0; k < NTX; k++) pay_v[8*k +: 8] = 8'($urandom);
      resp_a[0] = 8'h05; resp_a[1] = 8'h7F; resp_a[2] = 8'h80; resp_a[3] = 8'h7F;
      for (int j = 4; j < NRX; j++) resp_a[j] = 8'h00;
      run_txn("tie", NRX, -1, -1);

      // Bad stop bit on byte 4
      for (int k = 0; k < NTX; k++) pay_v[8*k +: 8] = 8'($urandom);
      for (int j = 0; j < NRX; j++) resp_a[j] = 8'($urandom);
      run_txn("framing", NRX, 4, -1);
      check_val("framing byte4", 128'(result_flat[39:32]), 128'(resp_a[4]));

      // Only three result bytes
      for (int k = 0; k < NTX; k++) pay_v[8*k +: 8] = 8'($urandom);
      for (int j = 0; j < NRX; j++) resp_a[j] = 8'($urandom);
      run_txn("timeout", 3, -1, -1);

      // Random traffic; also shows LOAD clearing the sticky flags
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < NTX; k++) pay_v[8*k +: 8] = 8'($urandom);
         for (int j = 0; j < NRX; j++) resp_a[j] = 8'($urandom);
         run_txn("random", NRX, -1, -1);
      end

      // start re-asserted while busy
      for (int k = 0; k < NTX; k++) pay_v[8*k +: 8] = 8'($urandom);
      for (int j = 0; j < NRX; j++) resp_a[j] = 8'($urandom);
      run_txn("restart ignored", NRX, -1, 200 + $urandom_range(0, 2000));

      // Reset during frame 20
      for (int k = 0; k < NTX; k++) pay_v[8*k +: 8] = 8'($urandom);
      in_vector_flat = pay_v;
      q_base = tx_q.size();
      start = 1'b1;
      @(negedge clk_100MHz);
      start = 1'b0;
      c = 0;
      while (c < 25 * 10 * CPB && (tx_q.size() - q_base) < 19) begin
         @(negedge clk_100MHz);
         c++;
      end
      repeat (3 * CPB) @(negedge clk_100MHz);
      check_val("midframe busy before reset", 128'(busy), 128'(1));
      rst = 1'b1;
      #1;
      check_val("midframe reset tx", 128'(tx), 128'(1));
      check_val("midframe reset busy", 128'(busy), 128'(0));
      @(negedge clk_100MHz);
      rst = 1'b0;
      repeat (12 * CPB) @(negedge clk_100MHz);

      for (int k = 0; k < NTX; k++) pay_v[8*k +: 8] = 8'($urandom);
      in_vector_flat = pay_v;
      q_base = tx_q.size();
      start = 1'b1;
      @(negedge clk_100MHz);
      start = 1'b0;
      c = 0;
      while (c < 20 * CPB && (tx_q.size() - q_base) < 1) begin
         @(negedge clk_100MHz);
         c++;
      end
      check_val("after reset frame seen", 128'(tx_q.size() > q_base), 128'(1));
      if (tx_q.size() > q_base) begin
         check_val("after reset first byte", 128'(tx_q[q_base]), 128'(pay_v[7:0]));
      end
      rst = 1'b1;
      repeat (2) @(negedge clk_100MHz);
      rst = 1'b0;
      repeat (2) @(negedge clk_100MHz);
      check_val("final idle tx", 128'(tx), 128'(1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_host_driver.md
UART_HOST_DRIVER -- requirements
Module: uart_host_driver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk_100MHz cycles per UART bit (115200 baud).
REQ-002 Parameter N_TX_BYTES, default 64, bytes sent per inference request.
REQ-003 Parameter N_RX_BYTES, default 10, bytes expected back per request.
REQ-004 Parameter TIMEOUT_CYCLES, default 50_000_000, maximum idle-line cycles allowed while awaiting a result byte.
REQ-005 Port clk_100MHz, input, 1, the only clock; one clock, and all flops are on its rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous and active-high.
REQ-007 Port start, input, 1, one-cycle request to run one transaction.
REQ-008 Port in_vector_flat, input, 8*N_TX_BYTES, payload; byte k = bits [8k+7:8k].
REQ-009 Port rx, input, 1, serial line from the accelerator's tx.
REQ-010 Port tx, output, 1, serial line to the accelerator's rx.
REQ-011 Port busy, output, 1, high from the accepted start until return to IDLE.
REQ-012 Port done, output, 1, one-cycle pulse when all N_RX_BYTES are received.
REQ-013 Port result_flat, output, 8*N_RX_BYTES, received bytes; byte j = bits [8j+7:8j].
REQ-014 Port argmax, output, 4, index of the largest signed result byte.
REQ-015 Ports timeout_err and frame_err, output, 1 each, sticky error flags.

Function
REQ-016 The FSM states are IDLE, LOAD, SEND_BYTE, WAIT_RX, RECV_BYTE, FINISH; a single transition occurs per cycle.
REQ-017 IDLE->LOAD on start=1; start is ignored when busy=1.
REQ-018 LOAD latches in_vector_flat into an internal buffer, clears result_flat, timeout_err, and frame_err, and clears the tx and rx counters in one cycle.
REQ-019 SEND_BYTE transmits 8N1 LSB-first, each bit lasting exactly CLKS_PER_BIT cycles, bytes in index order 0..N_TX_BYTES-1, back-to-back with no idle bits between frames.
REQ-020 After the stop bit of byte N_TX_BYTES-1 the FSM enters WAIT_RX; tx idles high in every state except SEND_BYTE.
REQ-021 rx passes through a 2-flop synchronizer; a start bit is a synchronized high->low transition detected in WAIT_RX.
REQ-022 RECV_BYTE recentres on the start bit at CLKS_PER_BIT/2; a low start bit at the centre is required, else the FSM returns to WAIT_RX with no byte counted.
REQ-023 RECV_BYTE samples data bits at their centres (LSB first) and checks the stop bit at its centre; stop=0 sets frame_err while the byte is still stored and counted.
REQ-024 Byte j is written to result_flat[8j+:8]; after byte N_RX_BYTES-1 the FSM enters FINISH, else WAIT_RX.
REQ-025 FINISH pulses done for exactly one cycle, then enters IDLE; result_flat holds until the next LOAD.
REQ-026 The WAIT_RX timer counts cycles since entering WAIT_RX; at TIMEOUT_CYCLES it sets timeout_err and returns to IDLE with no done pulse.
REQ-027 rx activity during IDLE, LOAD, or SEND_BYTE is ignored; no bytes are buffered.
REQ-028 Latency from start to the first tx falling edge is 2 cycles.

Reset
REQ-029 While rst=1 the block forces state=IDLE, tx=1, busy=0, done=0, result_flat=0, argmax=0, timeout_err=0, frame_err=0, and clears all counters.
REQ-030 Reset asserted mid-frame aborts immediately; tx returns high in the same cycle, and the partial transaction is not resumed.

Configuration
REQ-031 With ARGMAX_EN defined, argmax updates in FINISH to the index of the maximum two's-complement result byte; ties resolve to the lowest index, and the value is valid when done=1.
REQ-032 Without ARGMAX_EN, argmax is constant 0 and no comparator logic is built.

Verification
REQ-033 Payload byte k = k (0x00..0x3F), echo model returns 0x00..0x09 -> tx carries 64 frames in order, result_flat=0x09..00 (byte j = j), done pulses once, argmax=9.
REQ-034 Model returns bytes {0x05,0x7F,0x80,0x7F,0,0,0,0,0,0} -> argmax=1 (tie resolves to lowest index; 0x80 treated as -128).
REQ-035 Model sends only 3 bytes, TIMEOUT_CYCLES=1000 -> timeout_err=1 at cycle 1000 after the 3rd stop bit, busy=0, no done.
REQ-036 Model returns byte 4 with stop bit 0 -> frame_err=1, result_flat[39:32] holds the data, remaining bytes are received, done pulses.
REQ-037 rst pulsed during the 20th tx frame -> tx=1 and busy=0 in the same cycle; a new start then sends byte 0 first.
REQ-038 start asserted again while busy -> ignored; exactly 64 frames are sent and one done pulse occurs.
